// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Initiator side of the program-counter interface. Steers the program counter
//   (opcode/pc_in), reads back its pc_out, fetches the instruction word at that
//   address from instruction memory (req/ack) and hands it to decode
//   (valid/ready). Branch and halt requests from decode are honoured only on
//   the instruction handshake.
//
// Ports
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   start        in   1-cycle pulse: boot from IDLE / resume from HALTED
//   opcode       out  to PC: 0 RESET, 1 PRESET, 2 INCR, 3 HALT
//   pc_in        out  to PC: address operand
//   pc_out       in   from PC: current program counter
//   mem_req      out  instruction memory read request
//   mem_addr     out  read address, valid while mem_req=1
//   mem_ack      in   memory returns mem_rdata this cycle
//   mem_rdata    in   instruction word
//   instr_valid  out  instr_data/instr_addr valid to decode
//   instr_ready  in   decode accepts
//   instr_data   out  fetched word
//   instr_addr   out  address of fetched word
//   branch_valid in   redirect request (handshake only)
//   branch_tgt   in   redirect address
//   halt_req     in   stop request (handshake only, wins over branch)
//   halted       out  1 while HALTED
//   pc_err       out  sticky: pc_out differed from the expected address
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int              ADDR_W    = 16,
    parameter int              DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BOOT_ADDR = 16'h0000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic [1:0]        opcode,
    output logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] pc_out,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_tgt,
    input  logic              halt_req,
    output logic              halted,
    output logic              pc_err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_ISSUE  = 3'd4;
    localparam logic [2:0] ST_HALTED = 3'd5;

    localparam logic [1:0] OP_RESET  = 2'd0;
    localparam logic [1:0] OP_PRESET = 2'd1;
    localparam logic [1:0] OP_INCR   = 2'd2;
    localparam logic [1:0] OP_HALT   = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state_r,       state_s;
    logic [ADDR_W-1:0] exp_addr_r,    exp_addr_s;
    logic [1:0]        opcode_r,      opcode_s;
    logic [ADDR_W-1:0] pc_in_r,       pc_in_s;
    logic              mem_req_r,     mem_req_s;
    logic [ADDR_W-1:0] mem_addr_r,    mem_addr_s;
    logic              instr_valid_r, instr_valid_s;
    logic [DATA_W-1:0] instr_data_r,  instr_data_s;
    logic [ADDR_W-1:0] instr_addr_r,  instr_addr_s;
    logic              halted_r,      halted_s;
    logic              pc_err_r,      pc_err_s;

    logic              handshake_s;

    assign handshake_s = instr_valid_r & instr_ready;

    // Next-state and next-output computation for the fetch FSM.
    always_comb begin
        state_s       = state_r;
        exp_addr_s    = exp_addr_r;
        opcode_s      = opcode_r;
        pc_in_s       = pc_in_r;
        mem_req_s     = mem_req_r;
        mem_addr_s    = mem_addr_r;
        instr_valid_s = instr_valid_r;
        instr_data_s  = instr_data_r;
        instr_addr_s  = instr_addr_r;
        halted_s      = halted_r;
        pc_err_s      = pc_err_r;

        case (state_r)
            ST_IDLE: begin
                opcode_s = OP_RESET;
                if (start) begin
                    opcode_s   = OP_PRESET;
                    pc_in_s    = BOOT_ADDR;
                    exp_addr_s = BOOT_ADDR;
                    pc_err_s   = 1'b0;
                    state_s    = ST_SETTLE;
                end else begin
                    state_s    = ST_IDLE;
                end
            end

            // The PC applies the opcode issued on the previous edge here; from
            // now on PRESET/exp_addr is an idempotent hold.
            ST_SETTLE: begin
                opcode_s = OP_PRESET;
                pc_in_s  = exp_addr_r;
                state_s  = ST_FETCH;
            end

            // A mismatching PC is flagged but still trusted for the fetch.
            ST_FETCH: begin
                if (pc_out != exp_addr_r) begin
                    pc_err_s = 1'b1;
                end else begin
                    pc_err_s = pc_err_r;
                end
                mem_req_s  = 1'b1;
                mem_addr_s = pc_out;
                state_s    = ST_WAIT;
            end

            ST_WAIT: begin
                if (mem_ack) begin
                    mem_req_s     = 1'b0;
                    instr_data_s  = mem_rdata;
                    instr_addr_s  = mem_addr_r;
                    instr_valid_s = 1'b1;
                    state_s       = ST_ISSUE;
                end else begin
                    state_s       = ST_WAIT;
                end
            end

            ST_ISSUE: begin
                if (handshake_s) begin
                    instr_valid_s = 1'b0;
                    if (halt_req) begin
                        opcode_s = OP_HALT;
                        halted_s = 1'b1;
                        state_s  = ST_HALTED;
                    end else if (branch_valid) begin
                        opcode_s   = OP_PRESET;
                        pc_in_s    = branch_tgt;
                        exp_addr_s = branch_tgt;
                        state_s    = ST_SETTLE;
                    end else begin
                        opcode_s   = OP_INCR;
                        pc_in_s    = exp_addr_r;
                        exp_addr_s = exp_addr_r + ADDR_ONE;
                        state_s    = ST_SETTLE;
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end

            // PC replays pc_in (= exp_addr) under HALT, so resume is an INCR.
            ST_HALTED: begin
                if (start) begin
                    halted_s   = 1'b0;
                    opcode_s   = OP_INCR;
                    pc_in_s    = exp_addr_r;
                    exp_addr_s = exp_addr_r + ADDR_ONE;
                    state_s    = ST_SETTLE;
                end else begin
                    state_s    = ST_HALTED;
                end
            end

            default: begin
                opcode_s      = OP_RESET;
                mem_req_s     = 1'b0;
                instr_valid_s = 1'b0;
                halted_s      = 1'b0;
                state_s       = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any outstanding request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            exp_addr_r    <= {ADDR_W{1'b0}};
            opcode_r      <= OP_RESET;
            pc_in_r       <= {ADDR_W{1'b0}};
            mem_req_r     <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            instr_valid_r <= 1'b0;
            instr_data_r  <= {DATA_W{1'b0}};
            instr_addr_r  <= {ADDR_W{1'b0}};
            halted_r      <= 1'b0;
            pc_err_r      <= 1'b0;
        end else begin
            state_r       <= state_s;
            exp_addr_r    <= exp_addr_s;
            opcode_r      <= opcode_s;
            pc_in_r       <= pc_in_s;
            mem_req_r     <= mem_req_s;
            mem_addr_r    <= mem_addr_s;
            instr_valid_r <= instr_valid_s;
            instr_data_r  <= instr_data_s;
            instr_addr_r  <= instr_addr_s;
            halted_r      <= halted_s;
            pc_err_r      <= pc_err_s;
        end
    end

    assign opcode      = opcode_r;
    assign pc_in       = pc_in_r;
    assign mem_req     = mem_req_r;
    assign mem_addr    = mem_addr_r;
    assign instr_valid = instr_valid_r;
    assign instr_data  = instr_data_r;
    assign instr_addr  = instr_addr_r;
    assign halted      = halted_r;
    assign pc_err      = pc_err_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Self-checking bench for fetch_sequencer. Contains a behavioural program
//   counter, an instruction memory whose word is addr ^ 16'hA5C3, and a
//   scoreboard of expected fetch addresses. A second instance booting at
//   16'hFFFF runs free alongside the main one to cover address wrap.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    opcode;
    logic [AW-1:0] pc_in, pc_out, mem_addr, instr_addr;
    logic [AW-1:0] branch_tgt = 16'h0000;
    logic [DW-1:0] mem_rdata, instr_data;
    logic          mem_req, mem_ack, instr_valid, halted, pc_err;
    logic          instr_ready = 1'b0;
    logic          branch_valid = 1'b0;
    logic          halt_req = 1'b0;

    // second instance (BOOT_ADDR = FFFF)
    logic [1:0]    opcode_b;
    logic [AW-1:0] pc_in_b, pc_out_b, mem_addr_b, instr_addr_b;
    logic [DW-1:0] mem_rdata_b, instr_data_b;
    logic          mem_req_b, mem_ack_b, instr_valid_b, halted_b, pc_err_b;

    always #5 clock = ~clock;

    fetch_sequencer u_dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .opcode(opcode), .pc_in(pc_in), .pc_out(pc_out),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_addr(instr_addr),
        .branch_valid(branch_valid), .branch_tgt(branch_tgt), .halt_req(halt_req),
        .halted(halted), .pc_err(pc_err)
    );

    fetch_sequencer #(.BOOT_ADDR(16'hFFFF)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .start(start),
        .opcode(opcode_b), .pc_in(pc_in_b), .pc_out(pc_out_b),
        .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_ack(mem_ack_b), .mem_rdata(mem_rdata_b),
        .instr_valid(instr_valid_b), .instr_ready(1'b1),
        .instr_data(instr_data_b), .instr_addr(instr_addr_b),
        .branch_valid(1'b0), .branch_tgt(16'h0000), .halt_req(1'b0),
        .halted(halted_b), .pc_err(pc_err_b)
    );

    // ---------------- program counter model ----------------
    function automatic logic [AW-1:0] pc_next(input logic [1:0] op,
                                              input logic [AW-1:0] pc,
                                              input logic [AW-1:0] pin);
        case (op)
            2'd0:    return 16'h0000;
            2'd1:    return pin;
            2'd2:    return pc + 16'd1;
            default: return pin;
        endcase
    endfunction

    logic [AW-1:0] pc_r, pc_b_r;
    logic [AW-1:0] pc_corrupt = 16'h0000;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_r   <= 16'h0000;
            pc_b_r <= 16'h0000;
        end else begin
            pc_r   <= pc_next(opcode, pc_r, pc_in);
            pc_b_r <= pc_next(opcode_b, pc_b_r, pc_in_b);
        end
    end

    assign pc_out   = pc_r ^ pc_corrupt;
    assign pc_out_b = pc_b_r;

    // ---------------- memory model ----------------
    int   ack_delay = 0;
    int   wait_cnt  = 0;
    logic ack_force = 1'b0;

    always @(posedge clock) begin
        if (mem_req) wait_cnt <= wait_cnt + 1;
        else         wait_cnt <= 0;
    end

    assign mem_ack     = (mem_req && (wait_cnt >= ack_delay)) || ack_force;
    assign mem_rdata   = mem_addr ^ 16'hA5C3;
    assign mem_ack_b   = mem_req_b;
    assign mem_rdata_b = mem_addr_b ^ 16'hA5C3;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int            cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] model_last = 16'h0000;
    logic          sb_en = 1'b0;
    logic          mem_req_d = 1'b0;
    int            hs_count = 0;
    int            hs_cyc[$];

    // Scoreboard: check each new fetch and each accepted instruction, and
    // push the address the next fetch must use.
    always @(negedge clock) begin
        if (reset_n && sb_en) begin
            if (mem_req && !mem_req_d) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_fetch: got %0h expected none", mem_addr);
                end else begin
                    check("fetch_addr", mem_addr, exp_q[0]);
                end
            end
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_issue: got %0h expected none", instr_addr);
                end else begin
                    check("issue_addr", instr_addr, exp_q[0]);
                    check("issue_data", instr_data, exp_q[0] ^ 16'hA5C3);
                    model_last <= exp_q[0];
                    if (!halt_req) begin
                        if (branch_valid) exp_q.push_back(branch_tgt);
                        else              exp_q.push_back(exp_q[0] + 16'd1);
                    end
                    void'(exp_q.pop_front());
                    hs_count <= hs_count + 1;
                    hs_cyc.push_back(cyc);
                end
            end
        end
        mem_req_d <= mem_req;
    end

    // first three words delivered by the FFFF-boot instance
    logic [AW-1:0] b_addrs[$];
    always @(negedge clock) begin
        if (reset_n && instr_valid_b && b_addrs.size() < 3)
            b_addrs.push_back(instr_addr_b);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] first);
        exp_q.push_back(first);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        int target;
        target = hs_count + n;
        for (int i = 0; i < 200 && hs_count < target; i++) step();
        check("handshake_count", hs_count, target);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 100 && !mem_req; i++) step();
        check("mem_req_seen", mem_req, 1'b1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 100 && !instr_valid; i++) step();
        check("instr_valid_seen", instr_valid, 1'b1);
    endtask

    task automatic wait_halted();
        for (int i = 0; i < 100 && !halted; i++) step();
        check("halted_seen", halted, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {opcode, mem_req, instr_valid, halted, pc_err}, 64'd0);
        check({tag, "_data"}, {pc_in, mem_addr, instr_data, instr_addr}, 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
        branch_valid = 1'b0; halt_req = 1'b0; branch_tgt = 16'h0000;
        ack_force = 1'b0; ack_delay = 0; pc_corrupt = 16'h0000;
        exp_q.delete();
        step();
        step();
        check_zero("reset");
        reset_n = 1'b1;
        step();
    endtask

    // ---------------- decision table ----------------
    typedef struct {
        logic [AW-1:0] addr;   // instr_addr presented in ISSUE
        logic          br;
        logic          hl;
        logic [AW-1:0] tgt;
        logic [1:0]    op;     // opcode the cycle after handshake
        logic [AW-1:0] pin;    // pc_in the cycle after handshake
        logic          hlt;    // halted the cycle after handshake
    } vec_t;

    vec_t vecs[8];

    initial begin
        int nreq;
        vecs[0] = '{16'h0000, 1'b0, 1'b0, 16'h0000, 2'd2, 16'h0000, 1'b0};
        vecs[1] = '{16'h0001, 1'b0, 1'b0, 16'h0000, 2'd2, 16'h0001, 1'b0};
        vecs[2] = '{16'h0002, 1'b0, 1'b0, 16'h0000, 2'd2, 16'h0002, 1'b0};
        vecs[3] = '{16'h0003, 1'b0, 1'b0, 16'h0000, 2'd2, 16'h0003, 1'b0};
        vecs[4] = '{16'h0004, 1'b0, 1'b0, 16'h0000, 2'd2, 16'h0004, 1'b0};
        vecs[5] = '{16'h0005, 1'b1, 1'b0, 16'h1230, 2'd1, 16'h1230, 1'b0};
        vecs[6] = '{16'h1230, 1'b0, 1'b0, 16'h0000, 2'd2, 16'h1230, 1'b0};
        vecs[7] = '{16'h1231, 1'b1, 1'b1, 16'h4444, 2'd3, 16'h1231, 1'b1};

        // 1: boot, back-to-back fetches at full rate; FFFF instance wraps
        do_reset();
        sb_en = 1'b1;
        instr_ready = 1'b1;
        hs_cyc.delete();
        pulse_start(16'h0000);
        check("boot_opcode", opcode, 2'd1);
        check("boot_pc_in", pc_in, 16'h0000);
        wait_hs(3);
        check("hs_cyc_count", hs_cyc.size(), 3);
        if (hs_cyc.size() >= 3) begin
            check("issue_interval_1", hs_cyc[1] - hs_cyc[0], 4);
            check("issue_interval_2", hs_cyc[2] - hs_cyc[1], 4);
        end
        check("pc_err_clean", pc_err, 1'b0);
        check("wrap_count", b_addrs.size(), 3);
        if (b_addrs.size() == 3) begin
            check("wrap_addr0", b_addrs[0], 16'hFFFF);
            check("wrap_addr1", b_addrs[1], 16'h0000);
            check("wrap_addr2", b_addrs[2], 16'h0001);
        end
        check("wrap_pc_err", pc_err_b, 1'b0);

        // 2: handshake decisions (incr / branch / halt beats branch)
        do_reset();
        instr_ready = 1'b0;
        pulse_start(16'h0000);
        for (int i = 0; i < 8; i++) begin
            wait_valid();
            check($sformatf("vec%0d_addr", i), instr_addr, vecs[i].addr);
            branch_valid = vecs[i].br;
            halt_req     = vecs[i].hl;
            branch_tgt   = vecs[i].tgt;
            instr_ready  = 1'b1;
            step();
            check($sformatf("vec%0d_opcode", i), opcode, vecs[i].op);
            check($sformatf("vec%0d_pc_in", i), pc_in, vecs[i].pin);
            check($sformatf("vec%0d_halted", i), halted, vecs[i].hlt);
            instr_ready  = 1'b0;
            branch_valid = 1'b0;
            halt_req     = 1'b0;
        end
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            nreq += int'(mem_req);
        end
        check("halted_no_fetch", nreq, 0);
        check("halted_opcode", opcode, 2'd3);
        pulse_start(model_last + 16'd1);
        check("resume_opcode", opcode, 2'd2);
        check("resume_pc_in", pc_in, 16'h1231);
        check("resume_halted", halted, 1'b0);
        instr_ready = 1'b1;
        wait_hs(1);

        // 4: slow memory and stalled decode
        do_reset();
        ack_delay = 5;
        instr_ready = 1'b0;
        pulse_start(16'h0000);
        wait_req();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wait_hold%0d", i), {mem_req, mem_addr, opcode, pc_in},
                  {1'b1, 16'h0000, 2'd1, 16'h0000});
            step();
        end
        wait_valid();
        ack_delay = 0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("issue_hold%0d", i), {instr_valid, instr_data, instr_addr, opcode, pc_in},
                  {1'b1, 16'hA5C3, 16'h0000, 2'd1, 16'h0000});
            step();
        end
        instr_ready = 1'b1;
        step();
        check("post_hs_valid", instr_valid, 1'b0);
        check("post_hs_opcode", {opcode, pc_in}, {2'd2, 16'h0000});
        step();
        check("settle_opcode", {opcode, pc_in}, {2'd1, 16'h0001});
        wait_hs(1);

        // 5: program counter disagrees at FETCH
        do_reset();
        sb_en = 1'b0;
        instr_ready = 1'b1;
        pc_corrupt = 16'h0040;
        pulse_start(16'h0000);
        wait_req();
        check("err_set", pc_err, 1'b1);
        check("err_mem_addr", mem_addr, 16'h0040);
        pc_corrupt = 16'h0000;
        wait_valid();
        check("err_instr_addr", instr_addr, 16'h0040);
        check("err_instr_data", instr_data, 16'h0040 ^ 16'hA5C3);
        step();
        wait_valid();
        check("err_next_addr", instr_addr, 16'h0001);
        check("err_sticky", pc_err, 1'b1);

        // 6: reset in WAIT and in HALTED
        do_reset();
        sb_en = 1'b1;
        ack_delay = 20;
        instr_ready = 1'b1;
        pulse_start(16'h0000);
        wait_req();
        step();
        #2 reset_n = 1'b0;
        #1 check_zero("rst_wait");
        exp_q.delete();
        ack_force = 1'b1;
        step();
        reset_n = 1'b1;
        nreq = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            nreq += int'(mem_req | instr_valid | (opcode != 2'd0));
        end
        check("late_ack_ignored", nreq, 0);
        ack_force = 1'b0;
        ack_delay = 0;
        pulse_start(16'h0000);
        wait_hs(1);
        halt_req = 1'b1;
        wait_halted();
        halt_req = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_zero("rst_halted");
        exp_q.delete();
        step();
        reset_n = 1'b1;
        pulse_start(16'h0000);
        wait_hs(1);
        check("restart_pc_err", pc_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
